debounce_bank: RTL

DEBOUNCE_BANK -- requirements
Module: debounce_bank

---
 rtl/debounce_bank.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/debounce_bank.sv
// Bank of independent button debouncers sharing one sample tick, with press/release/long-press
// pulses and a per-channel up/down press counter. The release pulse port is named release_pulse
// because "release" is a reserved word in SystemVerilog.
module debounce_bank #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned TICK_DIV     = 4096,
    parameter int unsigned STABLE_TICKS = 15,
    parameter int unsigned LONG_TICKS   = 500,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       btn,
    input  logic [CHANNELS-1:0]       cnt_dn,
    input  logic [CHANNELS-1:0]       clear,
    output logic [CHANNELS-1:0]       level,
    output logic [CHANNELS-1:0]       press,
    output logic [CHANNELS-1:0]       release_pulse,
    output logic [CHANNELS-1:0]       long_press,
    output logic [CHANNELS*CNT_W-1:0] count
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    // One spare code so stable+1 never wraps, even with STABLE_TICKS of 1.
    localparam int unsigned SW = $clog2(STABLE_TICKS + 2);
    localparam int unsigned HW = $clog2(LONG_TICKS + 1);

    localparam logic [TW-1:0] TickLast  = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] StableMax = SW'(STABLE_TICKS);
    localparam logic [HW-1:0] HoldMax   = HW'(LONG_TICKS);

    typedef enum logic [1:0] {StRel, StChkP, StPrs, StChkR} state_e;

    logic [CHANNELS-1:0] sync1_q, sync2_q;
    logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
    logic                tick;

    state_e           state_q  [CHANNELS];
    state_e           state_d  [CHANNELS];
    logic [SW-1:0]    stable_q [CHANNELS];
    logic [SW-1:0]    stable_d [CHANNELS];
    logic [HW-1:0]    hold_q   [CHANNELS];
    logic [HW-1:0]    hold_d   [CHANNELS];
    logic [CNT_W-1:0] count_q  [CHANNELS];
    logic [CNT_W-1:0] count_d  [CHANNELS];

    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] press_q, press_d;
    logic [CHANNELS-1:0] rel_q, rel_d;
    logic [CHANNELS-1:0] long_q, long_d;

    always_comb begin
        tick       = (tick_cnt_q == TickLast);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    end

    always_comb begin
        level_d = level_q;
        press_d = '0;
        rel_d   = '0;
        long_d  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i]  = state_q[i];
            stable_d[i] = stable_q[i];
            hold_d[i]   = hold_q[i];
            count_d[i]  = count_q[i];
            if (tick) begin
                unique case (state_q[i])
                    StRel: begin
                        if (!sync2_q[i]) begin
                            state_d[i]  = StChkP;
                            stable_d[i] = SW'(1);
                        end
                    end
                    StChkP: begin
                        if (sync2_q[i]) begin
                            state_d[i] = StRel;
                        end else if (stable_q[i] + SW'(1) >= StableMax) begin
                            state_d[i]  = StPrs;
                            stable_d[i] = '0;
                            level_d[i]  = 1'b0;
                            press_d[i]  = 1'b1;
                            count_d[i]  = cnt_dn[i] ? count_q[i] - CNT_W'(1)
                                                    : count_q[i] + CNT_W'(1);
                        end else begin
                            stable_d[i] = stable_q[i] + SW'(1);
                        end
                    end
                    StPrs: begin
                        if (sync2_q[i]) begin
                            state_d[i]  = StChkR;
                            stable_d[i] = SW'(1);
                        end else if (hold_q[i] != HoldMax) begin
                            // Saturating at HoldMax makes the long pulse fire once per press.
                            hold_d[i] = hold_q[i] + HW'(1);
                            long_d[i] = (hold_q[i] + HW'(1) == HoldMax);
                        end
                    end
                    StChkR: begin
                        if (!sync2_q[i]) begin
                            state_d[i] = StPrs;
                        end else if (stable_q[i] + SW'(1) >= StableMax) begin
                            state_d[i]  = StRel;
                            stable_d[i] = '0;
                            hold_d[i]   = '0;
                            level_d[i]  = 1'b1;
                            rel_d[i]    = 1'b1;
                        end else begin
                            stable_d[i] = stable_q[i] + SW'(1);
                        end
                    end
                endcase
            end
            if (clear[i]) begin
                count_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            tick_cnt_q <= '0;
            level_q    <= '1;
            press_q    <= '0;
            rel_q      <= '0;
            long_q     <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]  <= StRel;
                stable_q[i] <= '0;
                hold_q[i]   <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            sync1_q    <= btn;
            sync2_q    <= sync1_q;
            tick_cnt_q <= tick_cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            rel_q      <= rel_d;
            long_q     <= long_d;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]  <= state_d[i];
                stable_q[i] <= stable_d[i];
                hold_q[i]   <= hold_d[i];
                count_q[i]  <= count_d[i];
            end
        end
    end

    always_comb begin
        level         = level_q;
        press         = press_q;
        release_pulse = rel_q;
        long_press    = long_q;
        count         = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            count[i*CNT_W +: CNT_W] = count_q[i];
        end
    end

endmodule
